// File: rtl/port_sched_pkg.sv
// Shared types and helpers for the port scheduler and its round-robin picker.
package port_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int WD_W = 16;
    localparam int ID_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/port_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick
    import port_sched_pkg::*;
#(
    parameter int NREQ  = 10,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        win_oh   = '0;
        win_idx  = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any     = 1'b1;
                win_idx = cand_idx;
            end
        end
        if (any) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/port_sched.sv
// Round-robin owner of a shared port: one-hot registered grant held for a burst,
// released on completion, withdrawal or watchdog, followed by a one-cycle drain gap.
module port_sched
    import port_sched_pkg::*;
#(
    parameter int NREQ  = 10,
    parameter int LEN_W = 8,
    parameter int TMO   = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*LEN_W-1:0] LEN,
    input  logic                  BEAT,
    output logic [NREQ-1:0]       GNT,
    output logic [ID_W-1:0]       GNT_ID,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  TMO_ERR,
    output state_e                DBG_STATE,
    output logic [ID_W-1:0]       DBG_PTR
);

    localparam int IDX_W = clog2(NREQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tmo_err_q, tmo_err_d;

    logic [NREQ-1:0]    win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [LEN_W-1:0]   win_len;
    logic               release_now;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req     (REQ),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_len = LEN[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tmo_err_d   = 1'b0;
        release_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d    = ST_GRANT;
                    gnt_d      = win_oh;
                    gnt_id_d   = win_idx;
                    busy_d     = 1'b1;
                    beat_cnt_d = (win_len == '0) ? LEN_W'(1) : win_len;
                    wd_cnt_d   = '0;
                    ptr_d      = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                end
            end
            ST_GRANT: begin
                if (BEAT) begin
                    wd_cnt_d = '0;
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    end
                end else if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
                // Completion outranks withdrawal, which outranks the watchdog.
                if (BEAT && beat_cnt_q == LEN_W'(1)) begin
                    done_d      = 1'b1;
                    release_now = 1'b1;
                end else if (!REQ[gnt_id_q]) begin
                    release_now = 1'b1;
                end else if (wd_cnt_q == WD_W'(TMO)) begin
                    tmo_err_d   = 1'b1;
                    release_now = 1'b1;
                end
                if (release_now) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            wd_cnt_q   <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign GNT       = gnt_q;
    assign GNT_ID    = ID_W'(gnt_id_q);
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TMO_ERR   = tmo_err_q;
    assign DBG_STATE = state_q;
    assign DBG_PTR   = ID_W'(ptr_q);

endmodule

// File: tb/tb_port_sched.sv
// Directed bench for port_sched: single burst, fairness, wrap/skip, withdrawal,
// watchdog and asynchronous reset mid-burst.
module tb_port_sched;
    import port_sched_pkg::*;

    localparam int NREQ  = 10;
    localparam int LEN_W = 8;
    localparam int TMO   = 15;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic                  beat;
    logic [NREQ-1:0]       gnt;
    logic [3:0]            gnt_id;
    logic                  busy;
    logic                  done;
    logic                  tmo_err;
    state_e                dbg_state;
    logic [3:0]            dbg_ptr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    port_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .TMO(TMO)) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ       (req),
        .LEN       (len),
        .BEAT      (beat),
        .GNT       (gnt),
        .GNT_ID    (gnt_id),
        .BUSY      (busy),
        .DONE      (done),
        .TMO_ERR   (tmo_err),
        .DBG_STATE (dbg_state),
        .DBG_PTR   (dbg_ptr)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        beat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_len_all(input int v);
        for (int i = 0; i < NREQ; i++) begin
            len[i*LEN_W +: LEN_W] = LEN_W'(v);
        end
    endtask

    task automatic set_len(input int idx, input int v);
        len[idx*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic drain();
        req  = '0;
        beat = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        logic [NREQ-1:0] exp_gnt;
        rst  = 1'b1;
        req  = '0;
        beat = 1'b0;
        len  = '0;

        // Reset values
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_tmo", 32'(tmo_err), 32'h0);
        check("rst_ptr", 32'(dbg_ptr), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Single request, 4 beats, then 2-cycle gap before re-grant
        set_len_all(1);
        set_len(3, 4);
        req  = 10'b0000001000;
        beat = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            exp_gnt = ((c >= 1 && c <= 4) || c == 7) ? 10'b0000001000 : 10'b0;
            check($sformatf("t1_gnt_c%0d", c), 32'(gnt), 32'(exp_gnt));
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(exp_gnt != '0));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 5));
            if (exp_gnt != '0) check($sformatf("t1_id_c%0d", c), 32'(gnt_id), 32'd3);
        end
        drain();
        check("t1_ptr", 32'(dbg_ptr), 32'd4);
        check("t1_state", 32'(dbg_state), 32'(ST_IDLE));

        // Fairness: all requesting, 1-beat bursts, grant every third edge
        do_reset();
        set_len_all(1);
        for (int k = 0; k <= 10; k++) exp_q.push_back(32'(k % NREQ));
        req  = '1;
        beat = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            step();
            if ((c - 1) % 3 == 0) begin
                exp_gnt = '0;
                exp_gnt[((c - 1) / 3) % NREQ] = 1'b1;
                if (exp_q.size() != 0) check($sformatf("t2_id_c%0d", c), 32'(gnt_id), exp_q.pop_front());
            end else begin
                exp_gnt = '0;
            end
            check($sformatf("t2_gnt_c%0d", c), 32'(gnt), 32'(exp_gnt));
        end
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);
        drain();
        check("t2_ptr", 32'(dbg_ptr), 32'd1);

        // Wrap and skip; final beat with REQ drop still completes
        do_reset();
        set_len_all(1);
        req  = 10'b0010000000;
        beat = 1'b1;
        step();
        check("t3_gnt7", 32'(gnt), 32'h080);
        check("t3_ptr8", 32'(dbg_ptr), 32'd8);
        req = 10'b0000000101;
        step();
        check("t3_done_drop", 32'(done), 32'd1);
        check("t3_gnt_rel", 32'(gnt), 32'h0);
        step();
        check("t3_gap", 32'(gnt), 32'h0);
        step();
        check("t3_gnt0", 32'(gnt), 32'h001);
        check("t3_id0", 32'(gnt_id), 32'd0);
        step();
        step();
        check("t3_gap2", 32'(gnt), 32'h0);
        step();
        check("t3_gnt2", 32'(gnt), 32'h004);
        check("t3_id2", 32'(gnt_id), 32'd2);
        drain();

        // Withdrawal after 3 beats; mid-burst LEN change ignored
        do_reset();
        set_len_all(1);
        set_len(5, 8);
        req  = 10'b0000100000;
        beat = 1'b1;
        step();
        check("t4_gnt5", 32'(gnt), 32'h020);
        check("t4_ptr", 32'(dbg_ptr), 32'd6);
        set_len(5, 1);
        for (int c = 2; c <= 4; c++) begin
            step();
            check($sformatf("t4_hold_c%0d", c), 32'(gnt), 32'h020);
            check($sformatf("t4_nodone_c%0d", c), 32'(done), 32'd0);
        end
        req = '0;
        step();
        check("t4_gnt_clr", 32'(gnt), 32'h0);
        check("t4_busy_clr", 32'(busy), 32'd0);
        check("t4_no_done", 32'(done), 32'd0);
        check("t4_no_tmo", 32'(tmo_err), 32'd0);
        check("t4_ptr_kept", 32'(dbg_ptr), 32'd6);
        drain();

        // Watchdog with LEN=0, then LEN=0 served as a 1-beat burst
        do_reset();
        set_len_all(0);
        req  = 10'b0000000010;
        beat = 1'b0;
        step();
        check("t5_gnt1", 32'(gnt), 32'h002);
        for (int c = 2; c <= 17; c++) begin
            step();
            check($sformatf("t5_tmo_c%0d", c), 32'(tmo_err), 32'(c == 17));
            check($sformatf("t5_gnt_c%0d", c), 32'(gnt), (c < 17) ? 32'h002 : 32'h0);
        end
        check("t5_no_done", 32'(done), 32'd0);
        beat = 1'b1;
        step();
        check("t5_tmo_pulse", 32'(tmo_err), 32'd0);
        check("t5_gap", 32'(gnt), 32'h0);
        step();
        check("t5_regnt", 32'(gnt), 32'h002);
        step();
        check("t5_len0_done", 32'(done), 32'd1);
        check("t5_len0_rel", 32'(gnt), 32'h0);
        drain();

        // Asynchronous reset mid-burst
        do_reset();
        set_len_all(6);
        req  = 10'b0010100000;
        beat = 1'b1;
        step();
        check("t6_gnt5", 32'(gnt), 32'h020);
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_gnt", 32'(gnt), 32'h0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_id", 32'(gnt_id), 32'd0);
        check("t6_async_ptr", 32'(dbg_ptr), 32'd0);
        #2;
        rst = 1'b0;
        step();
        check("t6_lowest", 32'(gnt), 32'h020);
        check("t6_lowest_id", 32'(gnt_id), 32'd5);
        drain();

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
